pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the single-cycle CPU.

---
 rtl/pc_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer for the
//   single-cycle CPU. The current PC goes out to an external adder, and the
//   incremented value comes back as pc_plus4. The next PC is chosen from three
//   sources: sequential, branch or jump. A fetched instruction is held in an
//   output register until decode accepts it.
//
// Parameters
//   DATA_WIDTH  width of PC, addresses and instruction word
//   RESET_PC    PC value loaded on reset
//   INC         byte increment the external adder applies; also sets the
//               instruction alignment (log2(INC) low address bits)
//
// Ports
//   clk            clock, all state on rising edge
//   rst            synchronous active-low reset
//   pc             current PC register (adder input a)
//   pc_plus4       adder output (pc + INC), modulo 2^DATA_WIDTH
//   branch_taken   redirect to branch_target this cycle
//   branch_target  branch destination
//   jump           redirect to jump_target this cycle (beats branch_taken)
//   jump_target    jump destination
//   imem_req       fetch request valid
//   imem_addr      fetch address (always equals pc)
//   imem_ready     imem_rdata valid for the current request
//   imem_rdata     fetched instruction
//   inst_valid     inst / inst_pc hold a valid instruction
//   inst_ready     decode accepts inst this cycle
//   inst           fetched instruction word
//   inst_pc        address inst was fetched from
//   misalign_err   one-cycle pulse: redirect target had nonzero low bits
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    INC        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  jump,
  input  logic [DATA_WIDTH-1:0] jump_target,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic                  misalign_err
);

  // Number of low address bits that must be zero for an instruction address.
  localparam int ALIGN_BITS = (INC > 1) ? $clog2(INC) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   pc_reg, pc_next;
  logic [DATA_WIDTH-1:0]   inst_reg, inst_next;
  logic [DATA_WIDTH-1:0]   inst_pc_reg, inst_pc_next;
  logic                    inst_valid_reg, inst_valid_next;
  logic                    misalign_reg, misalign_next;

  logic                    redirect;
  logic [DATA_WIDTH-1:0]   target_raw;
  logic [DATA_WIDTH-1:0]   target_aligned;
  logic                    target_misaligned;

  // Jump has priority over branch when both fire in the same cycle.
  assign redirect          = jump | branch_taken;
  assign target_raw        = jump ? jump_target : branch_target;
  assign target_misaligned = |target_raw[ALIGN_BITS-1:0];

  // Clear the alignment bits of the selected target; the rest pass through.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_align
      if (gi < ALIGN_BITS) begin : g_low
        assign target_aligned[gi] = 1'b0;
      end else begin : g_high
        assign target_aligned[gi] = target_raw[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
      misalign_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      inst_reg       <= inst_next;
      inst_pc_reg    <= inst_pc_next;
      inst_valid_reg <= inst_valid_next;
      misalign_reg   <= misalign_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    inst_next       = inst_reg;
    inst_pc_next    = inst_pc_reg;
    inst_valid_next = inst_valid_reg;
    misalign_next   = 1'b0;

    case (state_reg)
      // Single settling cycle after reset; redirects are not accepted here.
      IDLE: begin
        state_next = REQ;
      end

      REQ: begin
        if (redirect) begin
          // A response arriving in the same cycle belongs to the old path
          // and is discarded.
          pc_next       = target_aligned;
          misalign_next = target_misaligned;
        end else if (imem_ready) begin
          inst_next       = imem_rdata;
          inst_pc_next    = pc_reg;
          inst_valid_next = 1'b1;
          pc_next         = pc_plus4;
          state_next      = HOLD;
        end
      end

      HOLD: begin
        if (redirect) begin
          // Squash the held instruction: it is on the wrong path.
          inst_valid_next = 1'b0;
          pc_next         = target_aligned;
          misalign_next   = target_misaligned;
          state_next      = REQ;
        end else if (inst_ready) begin
          inst_valid_next = 1'b0;
          state_next      = REQ;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pc           = pc_reg;
  assign imem_req     = (state_reg == REQ);
  assign imem_addr    = pc_reg;
  assign inst_valid   = inst_valid_reg;
  assign inst         = inst_reg;
  assign inst_pc      = inst_pc_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb_q[$];

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] fetch_pc;
    logic [31:0] next_pc;
  } seq_vec_t;

  seq_vec_t seq_tab[3];

  pc_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h100),
    .INC       (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .misalign_err (misalign_err)
  );

  // External adder of the CPU datapath (pc + 4, modulo 2^32).
  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Drive a zero-wait response for the current request and record what decode
  // should later see.
  task automatic respond(input logic [31:0] exp_pc, input logic [31:0] word);
    imem_ready = 1'b1;
    imem_rdata = word;
    sb_q.push_back('{pc: exp_pc, word: word});
    step();
    imem_ready = 1'b0;
    imem_rdata = 32'hxxxx_xxxx;
  endtask

  // Pop the oldest expected instruction and compare it with the output register.
  task automatic expect_inst();
    exp_t e;
    int   n;
    n = 0;
    while (!inst_valid && n < 4) begin
      step();
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL inst_timeout: inst_valid got 0 expected 1 within 4 cycles");
    end else if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got output inst 0x%08h expected none", inst);
    end else begin
      e = sb_q.pop_front();
      check("sb_inst", inst, e.word);
      check("sb_inst_pc", inst_pc, e.pc);
    end
  endtask

  task automatic clear_redirect();
    jump          = 1'b0;
    branch_taken  = 1'b0;
    jump_target   = 32'h0;
    branch_target = 32'h0;
  endtask

  initial begin
    seq_tab[0] = '{rdata: 32'hA0, fetch_pc: 32'h100, next_pc: 32'h104};
    seq_tab[1] = '{rdata: 32'hA1, fetch_pc: 32'h104, next_pc: 32'h108};
    seq_tab[2] = '{rdata: 32'hA2, fetch_pc: 32'h108, next_pc: 32'h10C};

    rst        = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;
    clear_redirect();

    // Reset held for three edges
    repeat (3) step();
    check("rst_pc", pc, 32'h100);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);

    // Release; a jump during the IDLE cycle must be ignored.
    rst         = 1'b1;
    jump        = 1'b1;
    jump_target = 32'h500;
    step();
    clear_redirect();
    check("rel_imem_req", 32'(imem_req), 32'd1);
    check("rel_imem_addr", imem_addr, 32'h100);

    // Sequential fetch, table driven
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", imem_addr, seq_tab[i].fetch_pc);
      respond(seq_tab[i].fetch_pc, seq_tab[i].rdata);
      check("seq_hold_req", 32'(imem_req), 32'd0);
      check("seq_next_pc", pc, seq_tab[i].next_pc);
      expect_inst();
      step();
      check("seq_consumed_valid", 32'(inst_valid), 32'd0);
      check("seq_req_again", 32'(imem_req), 32'd1);
    end

    // Backpressure in HOLD
    inst_ready = 1'b0;
    respond(32'h10C, 32'hB0);
    expect_inst();
    imem_rdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_inst", inst, 32'hB0);
      check("bp_inst_pc", inst_pc, 32'h10C);
      check("bp_imem_req", 32'(imem_req), 32'd0);
      check("bp_pc", pc, 32'h110);
    end
    inst_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(inst_valid), 32'd0);
    check("bp_release_addr", imem_addr, 32'h110);

    // Jump + branch + response in REQ: jump wins, response dropped
    jump          = 1'b1;
    jump_target   = 32'h200;
    branch_taken  = 1'b1;
    branch_target = 32'h300;
    imem_ready    = 1'b1;
    imem_rdata    = 32'hDEAD;
    step();
    clear_redirect();
    imem_ready = 1'b0;
    check("req_redir_addr", imem_addr, 32'h200);
    check("req_redir_valid", 32'(inst_valid), 32'd0);
    check("req_redir_req", 32'(imem_req), 32'd1);
    check("req_redir_misalign", 32'(misalign_err), 32'd0);

    // Park an instruction in HOLD, then branch away from it
    inst_ready = 1'b0;
    respond(32'h200, 32'hC0);
    expect_inst();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    step();
    clear_redirect();
    check("hold_redir_valid", 32'(inst_valid), 32'd0);
    check("hold_redir_addr", imem_addr, 32'h40);
    check("hold_redir_misalign", 32'(misalign_err), 32'd0);

    // Misaligned branch from HOLD
    respond(32'h40, 32'hD0);
    expect_inst();
    branch_taken  = 1'b1;
    branch_target = 32'h43;
    step();
    clear_redirect();
    check("mis_valid", 32'(inst_valid), 32'd0);
    check("mis_addr", imem_addr, 32'h40);
    check("mis_pulse", 32'(misalign_err), 32'd1);
    step();
    check("mis_pulse_end", 32'(misalign_err), 32'd0);
    check("mis_addr_stable", imem_addr, 32'h40);
    check("mis_req", 32'(imem_req), 32'd1);

    // PC wrap
    jump        = 1'b1;
    jump_target = 32'hFFFF_FFFC;
    step();
    clear_redirect();
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    respond(32'hFFFF_FFFC, 32'hE0);
    expect_inst();
    check("wrap_pc", pc, 32'h0);
    inst_ready = 1'b1;
    step();
    check("wrap_fetch_addr", imem_addr, 32'h0);

    // Waiting request then reset with a simultaneous/late response
    repeat (2) step();
    check("wait_addr_stable", imem_addr, 32'h0);
    check("wait_req", 32'(imem_req), 32'd1);
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hF0;
    step();
    rst = 1'b1;
    check("midrst_pc", pc, 32'h100);
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(inst_valid), 32'd0);
    check("midrst_inst", inst, 32'h0);
    step();
    imem_ready = 1'b0;
    check("late_valid", 32'(inst_valid), 32'd0);
    check("late_addr", imem_addr, 32'h100);
    check("late_req", 32'(imem_req), 32'd1);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
